// File: rtl/match_scoreboard.sv
// Series scoreboard: tallies finished games per side from gameover rising edges,
// declares the series winner, celebrates for a fixed time, then waits for ack.
module match_scoreboard #(
  parameter int WIN_TARGET   = 3,
  parameter int CNT_W        = 4,
  parameter int CELEB_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gameover,
  input  logic [1:0]       who,
  input  logic             ack,
  output logic [CNT_W-1:0] winner_games,
  output logic [CNT_W-1:0] loser_games,
  output logic [1:0]       series_winner,
  output logic             celebrate,
  output logic             series_done,
  output logic             proto_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    CELEBRATE = 2'd1,
    DONE      = 2'd2
  } state_t;

  // The down-counter holds the remaining celebrate cycles minus one.
  localparam int CW = (CELEB_CYCLES > 1) ? $clog2(CELEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TARGET   = CNT_W'(WIN_TARGET);
  localparam logic [CW-1:0]    CEL_LOAD = CW'(CELEB_CYCLES - 1);

  state_t           r_state;
  logic             r_prev_go;
  logic [CW-1:0]    r_cel_cnt;
  logic [CNT_W-1:0] r_winner_games;
  logic [CNT_W-1:0] r_loser_games;
  logic [1:0]       r_series_winner;
  logic             r_celebrate;
  logic             r_series_done;
  logic             r_proto_err;

  logic             w_edge;
  logic [CNT_W-1:0] w_win_inc;
  logic [CNT_W-1:0] w_lose_inc;

  assign w_edge     = gameover & ~r_prev_go;
  assign w_win_inc  = r_winner_games + CNT_W'(1);
  assign w_lose_inc = r_loser_games + CNT_W'(1);

  always_ff @(posedge clk) begin
    // Edge history tracks gameover even in reset so a held level never counts on release.
    r_prev_go <= gameover;
    if (reset) begin
      r_state         <= PLAY;
      r_cel_cnt       <= '0;
      r_winner_games  <= '0;
      r_loser_games   <= '0;
      r_series_winner <= 2'b00;
      r_celebrate     <= 1'b0;
      r_series_done   <= 1'b0;
      r_proto_err     <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_edge) begin
            case (who)
              2'b10: begin
                r_winner_games <= w_win_inc;
                if (w_win_inc == TARGET) begin
                  r_series_winner <= 2'b10;
                  r_celebrate     <= 1'b1;
                  r_cel_cnt       <= CEL_LOAD;
                  r_state         <= CELEBRATE;
                end
              end
              2'b01: begin
                r_loser_games <= w_lose_inc;
                if (w_lose_inc == TARGET) begin
                  r_series_winner <= 2'b01;
                  r_celebrate     <= 1'b1;
                  r_cel_cnt       <= CEL_LOAD;
                  r_state         <= CELEBRATE;
                end
              end
              default: r_proto_err <= 1'b1;
            endcase
          end
        end
        CELEBRATE: begin
          if (r_cel_cnt == '0) begin
            r_celebrate   <= 1'b0;
            r_series_done <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_cel_cnt <= r_cel_cnt - CW'(1);
          end
        end
        DONE: begin
          // Any edge arriving with ack is dropped: the series resets instead.
          if (ack) begin
            r_winner_games  <= '0;
            r_loser_games   <= '0;
            r_series_winner <= 2'b00;
            r_series_done   <= 1'b0;
            r_state         <= PLAY;
          end
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  assign winner_games  = r_winner_games;
  assign loser_games   = r_loser_games;
  assign series_winner = r_series_winner;
  assign celebrate     = r_celebrate;
  assign series_done   = r_series_done;
  assign proto_err     = r_proto_err;
  assign dbg_state     = r_state;

endmodule

// File: doc/match_scoreboard.md
MATCH_SCOREBOARD -- requirements
Module: match_scoreboard

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 3, games one side must win to take the series; legal range 1..(2^CNT_W)-1.
REQ-002 SHALL have parameter CNT_W, default 4, width of each game tally.
REQ-003 SHALL have parameter CELEB_CYCLES, default 8, length of the celebrate phase in clocks; minimum 1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 gameover  in  1  game-end flag from the upstream game counter; a 0->1 transition marks one finished game.
REQ-008 who  in  2  game result, qualified by the gameover rising edge: 2'b10 = winner side, 2'b01 = loser side, 00/11 illegal.
REQ-009 ack  in  1  operator acknowledge of a finished series.
REQ-010 winner_games  out  CNT_W  games won by winner side in current series.
REQ-011 loser_games  out  CNT_W  games won by loser side in current series.
REQ-012 series_winner  out  2  series result, same encoding as who; 00 while the series is open.
REQ-013 celebrate  out  1  high during the CELEBRATE state.
REQ-014 series_done  out  1  high during the DONE state.
REQ-015 proto_err  out  1  sticky flag for an illegal who value.

Function
REQ-016 SHALL register gameover into prev_go every cycle, including reset cycles; edge = gameover & ~prev_go.
REQ-017 SHALL implement FSM states PLAY, CELEBRATE, DONE; all outputs registered.
REQ-018 PLAY, edge with who=10: winner_games += 1, visible after the sampling edge (1-cycle latency).
REQ-019 PLAY, edge with who=01: loser_games += 1, same latency.
REQ-020 PLAY, edge with who=00 or 11: no tally change; proto_err set to 1 and held until reset.
REQ-021 PLAY, increment making a tally equal WIN_TARGET: same edge loads series_winner with who and moves to CELEBRATE; the tally shows WIN_TARGET.
REQ-022 CELEBRATE: celebrate=1 for exactly CELEB_CYCLES cycles using an internal down-counter, then move to DONE.
REQ-023 DONE: series_done=1; tallies and series_winner are held.
REQ-024 DONE with ack=1: next cycle clears both tallies and series_winner to 00, clears series_done, and returns to PLAY.
REQ-025 Edges in CELEBRATE or DONE SHALL be ignored: no tally change and no proto_err.
REQ-026 ack in PLAY or CELEBRATE SHALL be ignored.
REQ-027 Tallies never exceed WIN_TARGET and never wrap.
REQ-028 A gameover level held high SHALL count once only; a new game needs gameover low for at least one sampled cycle.
REQ-029 Edge and ack in the same DONE cycle: ack is honoured and the edge is dropped.

Reset
REQ-030 reset=1 SHALL, on the next edge and regardless of state, force PLAY with winner_games=0, loser_games=0, series_winner=00, celebrate=0, series_done=0, proto_err=0 and the celebrate counter cleared.
REQ-031 Because prev_go tracks gameover during reset, gameover high across reset deassertion SHALL NOT count as a game.
REQ-032 Reset mid-CELEBRATE or mid-DONE SHALL abandon the series with no residual outputs.

Verification
REQ-033 Three gameover pulses with who=10 (defaults) -> winner_games 1,2,3; series_winner=10 with the third update; celebrate high 8 cycles; then series_done=1.
REQ-034 Mixed sequence 01,10,01,01 -> loser_games=3, winner_games=1, series_winner=01; ack in DONE -> next cycle all tallies 0, series_winner=00, PLAY.
REQ-035 gameover held high 20 cycles with who=10 -> winner_games=1 only.
REQ-036 Pulse with who=11 -> tallies unchanged, proto_err=1 and stays 1 after a later legal series; cleared only by reset.
REQ-037 Extra pulses and ack=1 during CELEBRATE -> no tally change, ack ignored, DONE still reached after 8 cycles.
REQ-038 reset in the 4th CELEBRATE cycle with gameover held high -> all outputs 0 next cycle; no game counted on reset release.
